// File: rtl/game_session_ctrl.sv
// game_session_ctrl: game supervisor for the arcade top level.
//   Generates the frame tick and runs the session FSM (idle/run/pause/hit/over).
//   Tracks lives and a BCD score.
//   Optional high score: define GAME_SESSION_HISCORE_EN to build the high-score register.
//   Without it, hiscore_bcd is tied to zero.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        start/jump button level
//   pause_switch pause request level
//   collision    collision level from the display logic
//   frame_tick   one-cycle pulse at FRAME_RATE
//   state        0=IDLE 1=RUN 2=PAUSE 3=HIT 4=OVER
//   lives        remaining lives, binary
//   life_leds    thermometer of lives (bit i set when lives > i)
//   game_over    high in OVER
//   score_en     high in RUN or HIT
//   score_bcd    current score, digit 0 in [3:0]
//   hiscore_bcd  best score (zero when the high-score option is not built)
module game_session_ctrl #(
   parameter int unsigned SYS_FREQ      = 100000000,
   parameter int unsigned FRAME_RATE    = 3,
   parameter int unsigned LIVES         = 3,
   parameter int unsigned SCORE_DIGITS  = 4,
   parameter int unsigned INVULN_FRAMES = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      pause_switch,
   input  logic                      collision,
   output logic                      frame_tick,
   output logic [2:0]                state,
   output logic [2:0]                lives,
   output logic [LIVES-1:0]          life_leds,
   output logic                      game_over,
   output logic                      score_en,
   output logic [4*SCORE_DIGITS-1:0] score_bcd,
   output logic [4*SCORE_DIGITS-1:0] hiscore_bcd
);

   localparam int unsigned DivTc = SYS_FREQ / FRAME_RATE - 1;
   localparam int unsigned DivW  = (DivTc > 0) ? $clog2(DivTc + 1) : 1;
   localparam int unsigned InvW  = $clog2(INVULN_FRAMES + 1);
   localparam int unsigned SW    = 4 * SCORE_DIGITS;

   localparam logic [DivW-1:0] DivTcV    = DivW'(DivTc);
   localparam logic [2:0]      LivesInit = 3'(LIVES);
   localparam logic [InvW-1:0] InvInit   = InvW'(INVULN_FRAMES);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StPause = 3'd2,
      StHit   = 3'd3,
      StOver  = 3'd4
   } state_e;

   state_e           state_q, state_d, ret_q, ret_d, hit_next;
   logic [DivW-1:0]  div_q, div_d;
   logic             tick_q;
   logic             start_q, coll_q;
   logic             start_rise, coll_rise;
   logic [2:0]       lives_q, lives_d;
   logic [InvW-1:0]  inv_q, inv_d;
   logic [SW-1:0]    score_q, score_d, score_inc;
   logic             all_nines, inc_carry, scoring;
   logic [LIVES-1:0] leds_q, leds_d;
   logic             game_over_q, game_over_d;
   logic             score_en_q, score_en_d;

   // Free-running frame divider, tick registered on the terminal count.
   always_comb begin
      div_d = (div_q == DivTcV) ? '0 : div_q + DivW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q   <= '0;
         tick_q  <= 1'b0;
         start_q <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         tick_q  <= (div_d == DivTcV);
         start_q <= start;
         coll_q  <= collision;
      end
   end

   assign start_rise = start & ~start_q;
   assign coll_rise  = collision & ~coll_q;

   // BCD ripple increment; all-9s saturates.
   always_comb begin
      score_inc = score_q;
      all_nines = 1'b1;
      inc_carry = 1'b1;
      for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
         if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
         if (inc_carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
               inc_carry = 1'b0;
            end
         end
      end
      if (all_nines) score_inc = score_q;
   end

   assign scoring = (state_q == StRun) || (state_q == StHit);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         ret_q       <= StRun;
         lives_q     <= LivesInit;
         inv_q       <= '0;
         score_q     <= '0;
         leds_q      <= '1;
         game_over_q <= 1'b0;
         score_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         lives_q     <= lives_d;
         inv_q       <= inv_d;
         score_q     <= score_d;
         leds_q      <= leds_d;
         game_over_q <= game_over_d;
         score_en_q  <= score_en_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      lives_d  = lives_q;
      inv_d    = inv_q;
      hit_next = StHit;
      score_d  = (tick_q && scoring) ? score_inc : score_q;
      case (state_q)
         StIdle, StOver: begin
            if (start_rise) begin
               state_d = StRun;
               lives_d = LivesInit;
               score_d = '0;
            end
         end
         StRun: begin
            // Collision wins over pause; pause is taken later from HIT or RUN.
            if (coll_rise) begin
               if (lives_q == 3'd1) begin
                  lives_d = '0;
                  state_d = StOver;
               end else begin
                  lives_d = lives_q - 3'd1;
                  inv_d   = InvInit;
                  state_d = StHit;
               end
            end else if (pause_switch) begin
               state_d = StPause;
               ret_d   = StRun;
            end
         end
         StHit: begin
            if (tick_q) begin
               inv_d = inv_q - InvW'(1);
               if (inv_q == InvW'(1)) hit_next = StRun;
            end
            // Pausing on the final tick resumes into RUN, not HIT.
            if (pause_switch) begin
               state_d = StPause;
               ret_d   = hit_next;
            end else begin
               state_d = hit_next;
            end
         end
         StPause: begin
            if (!pause_switch) state_d = ret_q;
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered outputs derive from next state so they line up with state.
   always_comb begin
      leds_d = '0;
      for (int i = 0; i < int'(LIVES); i++) begin
         leds_d[i] = (lives_d > 3'(i));
      end
      game_over_d = (state_d == StOver);
      score_en_d  = (state_d == StRun) || (state_d == StHit);
   end

`ifdef GAME_SESSION_HISCORE_EN
   logic [SW-1:0] hiscore_q;

   // Plain unsigned compare orders BCD correctly, most significant digit first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hiscore_q <= '0;
      end else if ((state_d == StOver) && (state_q != StOver) && (score_d > hiscore_q)) begin
         hiscore_q <= score_d;
      end
   end

   assign hiscore_bcd = hiscore_q;
`else
   assign hiscore_bcd = '0;
`endif

   assign frame_tick = tick_q;
   assign state      = state_q;
   assign lives      = lives_q;
   assign life_leds  = leds_q;
   assign game_over  = game_over_q;
   assign score_en   = score_en_q;
   assign score_bcd  = score_q;

endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
- Parametrised game supervisor; replaces the ad-hoc lives/game-over/score-enable glue and the fixed-rate frame divider in the arcade top level.
- Generates the game frame tick.
- Runs the session FSM: idle, run, pause, hit-invulnerability, over.
- Tracks N lives and an M-digit BCD score, plus an optional high score.
- Sits between the CPU/VGA collision and pause signals and the seven-segment and LED outputs.

Parameters:
SYS_FREQ, 100000000, system clock frequency in Hz
FRAME_RATE, 3, frame ticks per second; divider terminal count = SYS_FREQ/FRAME_RATE - 1
LIVES, 3, lives at session start, legal range 1..7
SCORE_DIGITS, 4, BCD score digits, legal range 1..8
INVULN_FRAMES, 4, frame ticks of collision immunity after a non-fatal hit, minimum 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  start/jump button, synchronous level
pause_switch  input  1  pause request level
collision  input  1  collision level from display logic
frame_tick  output  1  one-cycle pulse at FRAME_RATE
state  output  3  0=IDLE 1=RUN 2=PAUSE 3=HIT 4=OVER
lives  output  3  remaining lives, binary
life_leds  output  LIVES  thermometer of lives; bit i set when lives > i
game_over  output  1  high in OVER
score_en  output  1  high in RUN or HIT
score_bcd  output  4*SCORE_DIGITS  current score, digit 0 in [3:0]
hiscore_bcd  output  4*SCORE_DIGITS  best score

Behaviour:
Reset (reset low, asynchronous):
- state=IDLE; lives=LIVES; score=0; hiscore=0.
- Divider=0; frame_tick=0; edge registers=0.
- All outputs are registered.

Frame divider:
- Free-running in every state.
- Counts 0..SYS_FREQ/FRAME_RATE-1; frame_tick asserts for exactly one cycle on the terminal count.

Edge detection:
- start_rise and coll_rise come from one-cycle-delayed copies of start and collision.
- Edge registers reset to 0, so a level high at reset release counts as a rising edge.

FSM, evaluated each cycle:
- IDLE: on start_rise, go to RUN; load lives=LIVES; clear score.
- RUN:
  - coll_rise with lives==1: lives=0, go to OVER.
  - coll_rise with lives>1: lives-1, load invuln=INVULN_FRAMES, go to HIT.
  - Otherwise, if pause_switch: go to PAUSE, ret=RUN.
- HIT:
  - collision is ignored.
  - invuln decrements on frame_tick; when it reaches 0 on a tick, go to RUN.
  - If pause_switch: go to PAUSE, ret=HIT, invuln is held.
- PAUSE: divider keeps running, score frozen. When pause_switch is low, go to ret on the next cycle.
- OVER:
  - On entry, hiscore updates (see Optional Feature).
  - On start_rise, go to RUN with lives=LIVES and score=0; hiscore is retained.
- Unused encodings 5..7 go to IDLE.

Score:
- On frame_tick while score_en, score increments by 1 in BCD with ripple carry.
- At all-9s it saturates with no wrap.

Simultaneous events:
- coll_rise and pause_switch in the same RUN cycle: the collision is processed, and PAUSE is entered on a later cycle from HIT or RUN.
- frame_tick and coll_rise in the same RUN cycle: the score increments and the life is lost in that same cycle.
- The final frame_tick of HIT with pause_switch high: go to PAUSE with ret=RUN.

life_leds and game_over are registered from next-state lives/state, so they are aligned with state.

Optional Feature:
- Macro: GAME_SESSION_HISCORE_EN.
- Defined:
  - On the transition into OVER, if score > hiscore (unsigned BCD compare, most significant digit first), hiscore <= score.
  - hiscore_bcd drives the register.
- Undefined: no hiscore register; hiscore_bcd is constant 0.

Test Plan:
1. SYS_FREQ=20, FRAME_RATE=2. Release reset -> frame_tick pulses at cycles 9, 19, 29, each one cycle wide. state=0, lives=3, life_leds=3'b111.
2. Pulse start, then wait 12 ticks -> state=1, score_bcd=16'h0012, score_en=1. Force the score to 9999 and give one more tick -> score stays 9999.
3. In RUN with lives=3, raise collision for 50 cycles -> lives=2, state=3 for exactly 4 ticks then state=1, life_leds=3'b011. The collision still held during HIT causes no further loss.
4. In HIT with invuln=2, raise pause for 30 cycles -> state=2, score frozen, invuln held. Release pause -> state=3, and RUN is reached after 2 more ticks.
5. Three separate collision pulses from lives=3 -> after the third, state=4, game_over=1, lives=0, life_leds=0.
   - With GAME_SESSION_HISCORE_EN and score 0025: hiscore_bcd=0025.
   - Restart and die at 0010: hiscore stays 0025.
   - Without the macro: hiscore_bcd=0.
6. Drive reset low mid-RUN (score 0007, lives 2) without a clock edge -> outputs immediately return to the reset values, state=0, lives=3.
